// File: rtl/adders_pkg.sv
// Shared definitions for the adder family: controller states, default widths and
// the bit-index width used by the serial resolve stage.
package adders_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    HOLD    = 2'd2
  } acc_state_e;

  localparam int unsigned DefaultWidth    = 4;
  localparam int unsigned DefaultAccWidth = 8;
  localparam int unsigned DefaultIdxWidth = $clog2(DefaultAccWidth);

  // Width of a counter that indexes every bit of an n-bit vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csa_row_3to2.sv
// Row of full adders compressing three vectors into unshifted sum and carry vectors.
module csa_row_3to2 #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] cin,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);

  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (cin[i]),
      .sum  (sum[i]),
      .cout (carry[i])
    );
  end

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/carry_save_accumulator.sv
// Streaming multi-operand adder: operands compressed into a carry-save pair, then
// resolved to binary by a bit-serial ripple pass when the group's last operand arrives.
module carry_save_accumulator
  import adders_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned ACC_WIDTH = DefaultAccWidth
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_ovf
);

  localparam int unsigned IdxW = idx_width(ACC_WIDTH);

  acc_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] s_q, s_d;
  logic [ACC_WIDTH-1:0] c_q, c_d;
  logic [ACC_WIDTH-1:0] r_q, r_d;
  logic                 ovf_q, ovf_d;
  logic                 cy_q, cy_d;
  logic [IdxW-1:0]      idx_q, idx_d;

  logic [ACC_WIDTH-1:0] operand;
  logic [ACC_WIDTH-1:0] csa_sum;
  logic [ACC_WIDTH-1:0] csa_carry;
  logic                 ser_sum;
  logic                 ser_cout;

  assign operand = ACC_WIDTH'(in_data);

  csa_row_3to2 #(
    .N (ACC_WIDTH)
  ) u_csa (
    .a     (s_q),
    .b     (c_q),
    .cin   (operand),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  full_adder u_serial_fa (
    .a    (s_q[idx_q]),
    .b    (c_q[idx_q]),
    .cin  (cy_q),
    .sum  (ser_sum),
    .cout (ser_cout)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    cy_d    = cy_q;
    idx_d   = idx_q;
    unique case (state_q)
      ACCUM: begin
        if (in_valid) begin
          s_d = csa_sum;
          // Carry vector is stored pre-shifted; its top bit would fall off the accumulator.
          c_d   = {csa_carry[ACC_WIDTH-2:0], 1'b0};
          ovf_d = ovf_q | csa_carry[ACC_WIDTH-1];
          if (in_last) begin
            state_d = RESOLVE;
            idx_d   = '0;
            cy_d    = 1'b0;
          end
        end
      end
      RESOLVE: begin
        r_d[idx_q] = ser_sum;
        cy_d       = ser_cout;
        idx_d      = idx_q + 1'b1;
        if (idx_q == IdxW'(ACC_WIDTH - 1)) begin
          ovf_d   = ovf_q | ser_cout;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          s_d     = '0;
          c_d     = '0;
          r_d     = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      s_q     <= '0;
      c_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
      cy_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      cy_q    <= cy_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs are gated by state so the sticky overflow and partial result stay hidden.
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);
    out_sum   = (state_q == HOLD) ? r_q : '0;
    out_ovf   = (state_q == HOLD) ? ovf_q : 1'b0;
  end

endmodule
